// File: rtl/mdac_pkg.sv
// mdac_pkg: shared state encoding and default sizing for the door-access pattern path.
package mdac_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, UNLOCK, FAIL, LOCKOUT} state_t;
  localparam int N_DEF             = 4;
  localparam int UNLOCK_CYCLES_DEF = 8;
  localparam int MAX_FAILS_DEF     = 3;
  localparam int LOCK_CYCLES_DEF   = 16;
endpackage

// File: rtl/press_edge_detect.sv
// press_edge_detect: one-cycle press strobe on each rising edge of the debounced btn_valid level.
module press_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_valid_i,
  output logic press_o
);
  logic valid_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= btn_valid_i;
  assign press_o = btn_valid_i & ~valid_q;
endmodule

// File: rtl/pattern_entry_fsm.sv
// pattern_entry_fsm: collects serial key presses, samples the comparator and sequences unlock/error.
// Consecutive-failure lockout is built only when MDAC_LOCKOUT_EN is defined.
module pattern_entry_fsm
  import mdac_pkg::*;
#(
  parameter int N             = N_DEF,
  parameter int UNLOCK_CYCLES = UNLOCK_CYCLES_DEF
`ifdef MDAC_LOCKOUT_EN
  ,
  parameter int MAX_FAILS     = MAX_FAILS_DEF,
  parameter int LOCK_CYCLES   = LOCK_CYCLES_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_valid,
  input  logic                   btn_bit,
  input  logic                   clear,
  input  logic                   match,
  output logic [N-1:0]           entered,
  output logic [$clog2(N+1)-1:0] count,
  output logic                   check,
  output logic                   unlock,
  output logic                   error,
  output logic                   locked
);
  localparam int CW = $clog2(N+1);
`ifdef MDAC_LOCKOUT_EN
  localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int FW   = $clog2(MAX_FAILS+1);
`else
  localparam int TMAX = UNLOCK_CYCLES;
`endif
  localparam int TW = $clog2(TMAX+1);

  state_t          state_q, state_d;
  logic [N-1:0]    entered_q, entered_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            press;
`ifdef MDAC_LOCKOUT_EN
  logic [FW-1:0]   fail_q, fail_d;
`endif

  press_edge_detect u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_valid_i (btn_valid),
    .press_o     (press)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      entered_q <= '0;
      count_q   <= '0;
      timer_q   <= '0;
`ifdef MDAC_LOCKOUT_EN
      fail_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
`ifdef MDAC_LOCKOUT_EN
      fail_q    <= fail_d;
`endif
    end

  // Timers are loaded with length-1 on entry so the state lasts exactly the programmed cycles.
  always_comb begin
    state_d   = state_q;
    entered_d = entered_q;
    count_d   = count_q;
    timer_d   = timer_q;
`ifdef MDAC_LOCKOUT_EN
    fail_d    = fail_q;
`endif
    case (state_q)
      IDLE, COLLECT: begin
        if (clear) begin
          entered_d = '0;
          count_d   = '0;
          state_d   = IDLE;
        end else if (press) begin
          entered_d = {entered_q[N-2:0], btn_bit};
          count_d   = count_q + CW'(1);
          state_d   = (count_q == CW'(N-1)) ? CHECK : COLLECT;
        end
      end
      CHECK: begin
        state_d = match ? UNLOCK : FAIL;
        timer_d = TW'(UNLOCK_CYCLES-1);
`ifdef MDAC_LOCKOUT_EN
        fail_d  = match ? '0 : fail_q;
`endif
      end
      UNLOCK: begin
        state_d   = (timer_q == '0) ? IDLE : UNLOCK;
        timer_d   = (timer_q == '0) ? timer_q : timer_q - TW'(1);
        entered_d = (timer_q == '0) ? '0 : entered_q;
        count_d   = (timer_q == '0) ? '0 : count_q;
      end
      FAIL: begin
        entered_d = '0;
        count_d   = '0;
`ifdef MDAC_LOCKOUT_EN
        fail_d    = fail_q + FW'(1);
        state_d   = (fail_d == FW'(MAX_FAILS)) ? LOCKOUT : IDLE;
        timer_d   = TW'(LOCK_CYCLES-1);
`else
        state_d   = IDLE;
`endif
      end
`ifdef MDAC_LOCKOUT_EN
      LOCKOUT: begin
        state_d = (timer_q == '0) ? IDLE : LOCKOUT;
        timer_d = (timer_q == '0) ? timer_q : timer_q - TW'(1);
        fail_d  = (timer_q == '0) ? '0 : fail_q;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign entered = entered_q;
  assign count   = count_q;
  assign check   = (state_q == CHECK);
  assign unlock  = (state_q == UNLOCK);
  assign error   = (state_q == FAIL);
`ifdef MDAC_LOCKOUT_EN
  assign locked  = (state_q == LOCKOUT);
`else
  assign locked  = 1'b0;
`endif
endmodule

// File: doc/pattern_entry_fsm.md
Name: pattern_entry_fsm

Overview:
- Sequential front end of the door access path.
- Collects serial button presses into an N-bit entered pattern and presents it to the combinational pattern comparator.
- Samples the comparator's match result and drives the unlock, error and lockout indications.
- Sits between the debounced keypad inputs and the comparator/actuator.

Parameters:
N, 4, number of pattern bits; must match the comparator width
UNLOCK_CYCLES, 8, cycles unlock stays high after a correct entry
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (LOCKOUT_EN only)
LOCK_CYCLES, 16, cycles the lockout lasts (LOCKOUT_EN only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_valid  input  1  press strobe (debounced level); one press per rising edge
btn_bit  input  1  value of the pressed key (0/1)
clear  input  1  abandon the current entry
match  input  1  comparator result for the current entered value
entered  output  N  assembled pattern, wired to the comparator
count  output  $clog2(N+1)  presses collected so far
check  output  1  one-cycle strobe; match is sampled this cycle
unlock  output  1  door release
error  output  1  one-cycle failed-attempt pulse
locked  output  1  lockout active; presses ignored

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; entered=0, count=0, fail_cnt=0.
  - check, unlock, error and locked all 0.
  - Internal previous-btn_valid register=0, so btn_valid already high at reset release counts as one press.
- Press detection: press = btn_valid & ~btn_valid_q.
  - Holding btn_valid high counts once.
  - Presses are accepted only in IDLE and COLLECT; they are ignored elsewhere, including the edge.
- On an accepted press:
  - entered <= {entered[N-2:0], btn_bit} (first press ends up in the MSB).
  - count <= count+1, both updated at the same edge.
  - The state moves IDLE->COLLECT.
  - The press that makes count==N moves the state to CHECK at that same edge.
- clear: in IDLE/COLLECT, entered<=0, count<=0 and state<=IDLE. It overrides a same-cycle press. It is ignored in all other states.
- CHECK (exactly 1 cycle):
  - check=1 and match is sampled.
  - match=1 -> UNLOCK; fail_cnt<=0.
  - match=0 -> FAIL.
- UNLOCK:
  - unlock=1 for exactly UNLOCK_CYCLES cycles, counted by an internal down-counter.
  - Then IDLE with entered<=0 and count<=0.
- FAIL (exactly 1 cycle):
  - error=1; entered<=0, count<=0; fail_cnt<=fail_cnt+1.
  - If fail_cnt+1==MAX_FAILS -> LOCKOUT; otherwise -> IDLE.
- LOCKOUT:
  - locked=1 for exactly LOCK_CYCLES cycles.
  - Then IDLE with fail_cnt<=0.
- Output timing: all outputs are registered or decoded from registered state. There is no combinational path from an input to an output.
- Reset mid-operation (any state): immediate return to reset values, with no completion pulse.
- Timer widths: $clog2(max(UNLOCK_CYCLES,LOCK_CYCLES)+1) bits. The timer is loaded on state entry and decrements to 0 with no wrap.

Optional Feature:
MDAC_LOCKOUT_EN
- Defined: fail_cnt, the LOCKOUT state and the locked output behave as above.
- Undefined:
  - No fail counter and no LOCKOUT state.
  - FAIL always returns to IDLE.
  - locked is tied to 0.
  - MAX_FAILS and LOCK_CYCLES are unused.

Decomposition:
- Package mdac_pkg:
  - State enum {IDLE, COLLECT, CHECK, UNLOCK, FAIL, LOCKOUT}.
  - Default constants for N, UNLOCK_CYCLES, MAX_FAILS and LOCK_CYCLES, shared with the comparator so widths cannot diverge.
- Sub-module: press_edge_detect, the registered rising-edge detector on btn_valid.
- The FSM, shift register and timers stay in this module.

Test Plan:
- Correct entry: N=4, the bench models match = (entered==4'b1011).
  - Stimulus: presses 1,0,1,1.
  - Response: entered=4'b1011, count=4, check high 1 cycle, then unlock high exactly 8 cycles, then entered=0 and count=0.
- Held button: btn_valid held high for 5 cycles with btn_bit=1 -> count=1 and entered=4'b0001.
- Clear priority: presses 1,0, then clear asserted together with a third press -> entered=0, count=0, state IDLE.
- Wrong entry without lockout: presses 0,0,0,0 -> check pulse, error high 1 cycle, locked=0, ready for a new entry.
- Lockout (MDAC_LOCKOUT_EN):
  - Stimulus: 3 wrong entries in a row.
  - Response: the third error pulse is followed by locked high exactly 16 cycles.
  - Presses during lockout change neither count nor entered.
  - Afterwards, a correct entry unlocks.
  - Also check that a success between failures resets fail_cnt, so two wrong, one right, two wrong gives no lockout.
- Async reset mid-UNLOCK: drive rst_n=0 on cycle 3 of unlock -> unlock drops at once and all outputs return to 0.
